// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-locked sharing of one FIFO write port.
// No write is issued while the FIFO reports full.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  output logic [NUM_REQ-1:0]            o_ready,
  input  logic                          i_fifo_full,
  output logic                          o_fifo_wen,
  output logic [DATA_WIDTH-1:0]         o_fifo_data,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic                          o_busy
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state;
  logic [IW-1:0]        last_grant;
  logic [IW-1:0]        gidx;
  logic [IW-1:0]        sel_idx;
  logic [IW:0]          pos;
  logic                 found;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 any_valid;
  logic                 grant_valid;
  logic                 last_beat;

  always_comb begin
    gidx        = '0;
    o_fifo_data = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (o_grant[k]) begin
        gidx        = IW'(k);
        o_fifo_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        grant_valid = i_valid[k];
      end
    end
  end

  // scan upward from last_grant+1, wrapping modulo NUM_REQ
  always_comb begin
    sel_idx = last_grant;
    found   = 1'b0;
    pos     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      pos = {1'b0, last_grant} + (IW+1)'(i);
      if (pos >= (IW+1)'(NUM_REQ))
        pos = pos - (IW+1)'(NUM_REQ);
      if (!found && i_valid[pos[IW-1:0]]) begin
        found   = 1'b1;
        sel_idx = pos[IW-1:0];
      end
    end
  end

  assign any_valid  = |i_valid;
  assign last_beat  = beat_cnt == CNT_WIDTH'(BURST_LEN-1);
  assign o_busy     = state == GRANT;
  assign o_ready    = o_busy ? (o_grant & {NUM_REQ{~i_fifo_full}}) : '0;
  assign o_fifo_wen = o_busy & grant_valid & ~i_fifo_full;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_grant    <= '0;
      beat_cnt   <= '0;
      last_grant <= IW'(NUM_REQ-1);
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state    <= GRANT;
            o_grant  <= NUM_REQ'(1) << sel_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (!grant_valid || (o_fifo_wen && last_beat)) begin
            state      <= IDLE;
            o_grant    <= '0;
            beat_cnt   <= '0;
            last_grant <= gidx;
          end else if (o_fifo_wen) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
